// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: state encodings, counter width,
// and the clock-derived divider/debounce lengths used by the counter,
// the FND driver and this controller.
package stopwatch_pkg;

    localparam int CNT_W = 14;

    typedef logic [1:0] sw_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LAP  = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;

    // Clock cycles per counter tick.
    function automatic int calc_tick_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Clock cycles a button must be stable before the debounced level moves.
    function automatic int calc_deb_cyc(input int clk_hz, input int deb_ms);
        return (clk_hz / 1000) * deb_ms;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle pulse on each debounced press (release gives no pulse).
module btn_debounce #(
    parameter int DEB_CYC = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_press
);

    // Counter only needs to reach DEB_CYC-1; keep at least one bit.
    localparam int CW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // Next-state: the level flips once the synchronized input has differed
    // from it for DEB_CYC consecutive cycles; any agreement restarts the count.
    always_comb begin
        sync1_d = i_btn;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        press_d = level_d & ~level_q;
    end

    // State registers; reset drops any partially counted debounce window.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/stop/lap controller: debounces the two buttons, runs the
// IDLE/RUN/LAP/STOP machine, generates tick, run enable and clear for the
// counter, and selects the value shown on the FND.
// Optional feature: define STOPWATCH_LAP_EN to build the LAP state, the
// lap register and the frozen display; without it lap only clears from STOP.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 10,
    parameter int DEB_MS  = 20
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_btn_run,
    input  logic             i_btn_lap,
    input  logic [CNT_W-1:0] i_cnt_value,
    output logic             o_tick,
    output logic             o_runstop,
    output logic             o_clear_n,
    output logic [CNT_W-1:0] o_disp_value,
    output logic [1:0]       o_state
);

    localparam int TICK_DIV = calc_tick_div(CLK_HZ, TICK_HZ);
    localparam int DEB_CYC  = calc_deb_cyc(CLK_HZ, DEB_MS);
    localparam int DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic             run_press;
    logic             lap_press;
    logic             running;

    sw_state_t        state_q,   state_d;
    logic             clear_n_q, clear_n_d;
    logic [DIV_W-1:0] div_q,     div_d;
    logic             tick_q,    tick_d;
    logic [CNT_W-1:0] disp_q,    disp_d;
`ifdef STOPWATCH_LAP_EN
    logic [CNT_W-1:0] lap_val_q, lap_val_d;
`endif

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_run (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_run),
        .o_press (run_press)
    );

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_lap (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_lap),
        .o_press (lap_press)
    );

    assign running = (state_q == ST_RUN) || (state_q == ST_LAP);

    // FSM transitions; the run press is tested first so it wins a tie.
    always_comb begin
        state_d   = state_q;
        clear_n_d = 1'b1;
`ifdef STOPWATCH_LAP_EN
        lap_val_d = lap_val_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (run_press) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (run_press) begin
                    state_d = ST_STOP;
`ifdef STOPWATCH_LAP_EN
                end else if (lap_press) begin
                    state_d   = ST_LAP;
                    lap_val_d = i_cnt_value;
`endif
                end
            end
`ifdef STOPWATCH_LAP_EN
            ST_LAP: begin
                if (run_press)      state_d = ST_STOP;
                else if (lap_press) state_d = ST_RUN;
            end
`endif
            ST_STOP: begin
                if (run_press) begin
                    state_d = ST_RUN;
                end else if (lap_press) begin
                    state_d   = ST_IDLE;
                    clear_n_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Tick divider: free-runs while running, freezes in STOP so a resumed
    // run keeps its partial period, and is parked at zero in IDLE.
    always_comb begin
        div_d  = div_q;
        tick_d = 1'b0;
        if (running) begin
            tick_d = (div_q == DIV_LAST);
            div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end else if (state_q == ST_IDLE) begin
            div_d = '0;
        end
    end

    // Display source follows the state being entered, so the frozen lap
    // value appears together with o_state reading LAP.
    always_comb begin
`ifdef STOPWATCH_LAP_EN
        disp_d = (state_d == ST_LAP) ? lap_val_d : i_cnt_value;
`else
        disp_d = i_cnt_value;
`endif
    end

    // State registers; clear is held active while in reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            clear_n_q <= 1'b0;
            div_q     <= '0;
            tick_q    <= 1'b0;
            disp_q    <= '0;
`ifdef STOPWATCH_LAP_EN
            lap_val_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            clear_n_q <= clear_n_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
            disp_q    <= disp_d;
`ifdef STOPWATCH_LAP_EN
            lap_val_q <= lap_val_d;
`endif
        end
    end

    assign o_tick       = tick_q;
    assign o_runstop    = running;
    assign o_clear_n    = clear_n_q;
    assign o_disp_value = disp_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl at CLK_HZ=1000, TICK_HZ=10, DEB_MS=2.
module tb_stopwatch_ctrl;

    localparam int TD = 100;
    localparam int DC = 2;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_run;
    logic        btn_lap;
    logic [13:0] cnt_val;
    logic        o_tick;
    logic        o_runstop;
    logic        o_clear_n;
    logic [13:0] o_disp_value;
    logic [1:0]  o_state;

    stopwatch_ctrl #(
        .CLK_HZ  (1000),
        .TICK_HZ (10),
        .DEB_MS  (2)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_btn_run    (btn_run),
        .i_btn_lap    (btn_lap),
        .i_cnt_value  (cnt_val),
        .o_tick       (o_tick),
        .o_runstop    (o_runstop),
        .o_clear_n    (o_clear_n),
        .o_disp_value (o_disp_value),
        .o_state      (o_state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          run_hold = 0;
    int          lap_hold = 0;
    bit          auto_cnt = 1'b0;
    logic [13:0] cnt_at_edge = '0;

    // ---------------- reference model ----------------
    // State numbers are the o_state values; the debounced level is judged
    // from a window of raw samples, and ticks from the total count of
    // running cycles since the last IDLE.
    int              m_state  = 0;
    int              m_lap    = 0;
    int              m_disp   = 0;
    int              m_runcnt = 0;
    bit              m_tick   = 1'b0;
    bit              m_clr_n  = 1'b0;
    bit              m_lvl_run = 1'b0, m_lvl_lap = 1'b0;
    bit              m_prs_run = 1'b0, m_prs_lap = 1'b0;
    logic [DC+1:0]   h_run = '0, h_lap = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_lap = 0; m_disp = 0; m_runcnt = 0;
            m_tick = 1'b0; m_clr_n = 1'b0;
            m_lvl_run = 1'b0; m_lvl_lap = 1'b0;
            m_prs_run = 1'b0; m_prs_lap = 1'b0;
            h_run = '0; h_lap = '0;
        end else begin
            int ns;
            bit rp, lp, nl;
            rp = m_prs_run;
            lp = m_prs_lap && !m_prs_run;
            ns = m_state;
            m_clr_n = 1'b1;
            case (m_state)
                0: if (rp) ns = 1;
                1: begin
                    if (rp) ns = 3;
                    else if (lp && LAP_EN) begin ns = 2; m_lap = int'(cnt_val); end
                end
                2: begin
                    if (rp) ns = 3;
                    else if (lp) ns = 1;
                end
                default: begin
                    if (rp) ns = 1;
                    else if (lp) begin ns = 0; m_clr_n = 1'b0; end
                end
            endcase
            if (m_state == 1 || m_state == 2) begin
                m_runcnt++;
                m_tick = (m_runcnt % TD) == 0;
            end else begin
                m_tick = 1'b0;
                if (m_state == 0) m_runcnt = 0;
            end
            m_disp  = (ns == 2) ? m_lap : int'(cnt_val);
            m_state = ns;
            h_run = {h_run[DC:0], btn_run};
            h_lap = {h_lap[DC:0], btn_lap};
            nl = (h_run[DC+1:2] == {DC{~m_lvl_run}}) ? ~m_lvl_run : m_lvl_run;
            m_prs_run = nl && !m_lvl_run;
            m_lvl_run = nl;
            nl = (h_lap[DC+1:2] == {DC{~m_lvl_lap}}) ? ~m_lvl_lap : m_lvl_lap;
            m_prs_lap = nl && !m_lvl_lap;
            m_lvl_lap = nl;
        end
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic compare_model(input string pfx);
        check_val({pfx, "_state"},   o_state,      m_state);
        check_val({pfx, "_runstop"}, o_runstop,    (m_state == 1 || m_state == 2) ? 1 : 0);
        check_val({pfx, "_tick"},    o_tick,       m_tick);
        check_val({pfx, "_clear_n"}, o_clear_n,    m_clr_n);
        check_val({pfx, "_disp"},    o_disp_value, m_disp);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        cyc++;
        cnt_at_edge = cnt_val;
        compare_model("cyc");
        if (run_hold > 0) begin
            run_hold--;
            if (run_hold == 0) btn_run = 1'b0;
        end
        if (lap_hold > 0) begin
            lap_hold--;
            if (lap_hold == 0) btn_lap = 1'b0;
        end
        if (auto_cnt) cnt_val = (cnt_val == 14'd9599) ? 14'd0 : cnt_val + 14'd1;
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press_run(input int n);
        btn_run = 1'b1;
        run_hold = n;
    endtask

    task automatic press_lap(input int n);
        btn_lap = 1'b1;
        lap_hold = n;
    endtask

    task automatic wait_runstop(input logic val, input int limit, output int waited);
        waited = 0;
        while (o_runstop !== val && waited < limit) begin
            step();
            waited++;
        end
    endtask

    task automatic wait_tick(input int limit, output int waited);
        waited = 0;
        do begin
            step();
            waited++;
        end while (o_tick !== 1'b1 && waited < limit);
    endtask

    task automatic count_clear_low(input int n, output int lows, output int st_at);
        lows = 0;
        st_at = -1;
        for (int i = 0; i < n; i++) begin
            step();
            if (o_clear_n === 1'b0) begin
                lows++;
                st_at = int'(o_state);
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int w, r, run_len, lows, st_at;
        rst_n = 1'b1; btn_run = 1'b0; btn_lap = 1'b0; cnt_val = '0;
        #3 rst_n = 1'b0;
        #1 compare_model("rst");
        check_val("rst_clear_n", o_clear_n, 0);
        check_val("rst_disp", o_disp_value, 0);
        run_steps(3);
        rst_n = 1'b1;
        run_steps(3);
        check_val("post_rst_clear_n", o_clear_n, 1);

        // single-cycle glitch must not register
        press_run(1);
        run_steps(12);
        check_val("glitch_state", o_state, 0);
        check_val("glitch_clear_n", o_clear_n, 1);

        // run press latency and tick spacing
        press_run(10);
        wait_runstop(1'b1, 20, w);
        check_val("run_latency", w, 5);
        check_val("run_state", o_state, 1);
        r = cyc;
        wait_tick(300, w);
        check_val("first_tick", w, TD);
        wait_tick(300, w);
        check_val("second_tick", w, TD);

        // stop after 250 running cycles, resume keeps the partial period
        run_steps(r + 245 - cyc);
        press_run(4);
        wait_runstop(1'b0, 20, w);
        run_len = cyc - r;
        check_val("run_len", run_len, 250);
        check_val("stop_state", o_state, 3);
        run_steps(500);
        press_run(4);
        wait_runstop(1'b1, 20, w);
        wait_tick(300, w);
        check_val("resume_tick", w, TD - (run_len % TD));

        // lap freeze and release
        cnt_val = 14'd1234;
        run_steps(2);
        press_lap(4);
        run_steps(6);
        auto_cnt = 1'b1;
        run_steps(20);
        if (LAP_EN) begin
            check_val("lap_state", o_state, 2);
            check_val("lap_disp", o_disp_value, 1234);
        end else begin
            check_val("nolap_state", o_state, 1);
            check_val("nolap_disp", o_disp_value, cnt_at_edge);
        end
        check_val("lap_runstop", o_runstop, 1);
        press_lap(4);
        run_steps(8);
        check_val("unlap_state", o_state, 1);
        check_val("disp_live", o_disp_value, cnt_at_edge);
        auto_cnt = 1'b0;

        // stop then lap clears once and returns to IDLE
        press_run(4);
        run_steps(8);
        check_val("stop2_state", o_state, 3);
        press_lap(4);
        count_clear_low(15, lows, st_at);
        check_val("clear_pulses", lows, 1);
        check_val("clear_state", st_at, 0);
        check_val("idle_state", o_state, 0);

        // both buttons together from STOP: run wins, no clear
        press_run(4);
        run_steps(8);
        press_run(4);
        run_steps(8);
        check_val("stop3_state", o_state, 3);
        press_run(4);
        press_lap(4);
        count_clear_low(12, lows, st_at);
        check_val("both_clear", lows, 0);
        check_val("both_state", o_state, 1);

        // reset while in LAP
        press_lap(4);
        run_steps(8);
        check_val("lap2_state", o_state, LAP_EN ? 2 : 1);
        rst_n = 1'b0;
        #1 compare_model("rst_mid");
        check_val("rst_mid_state", o_state, 0);
        check_val("rst_mid_runstop", o_runstop, 0);
        check_val("rst_mid_clear_n", o_clear_n, 0);
        check_val("rst_mid_disp", o_disp_value, 0);
        run_steps(2);
        rst_n = 1'b1;
        run_steps(2);
        press_lap(4);
        run_steps(12);
        check_val("lap_after_rst", o_state, 0);

        // randomized phase against the model
        for (int i = 0; i < 4000; i++) begin
            if (run_hold == 0 && $urandom_range(0, 24) == 0) press_run(int'($urandom_range(1, 8)));
            if (lap_hold == 0 && $urandom_range(0, 24) == 0) press_lap(int'($urandom_range(1, 8)));
            if ($urandom_range(0, 7) == 0) cnt_val = 14'($urandom_range(0, 9599));
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                #1 compare_model("rnd_rst");
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run/stop/lap controller sitting between the board push-buttons and the stopwatch counter. Debounces two buttons, runs the stopwatch state machine, and generates the counter's tenth-of-second tick, run enable and clear pulse. Also owns the value shown on the FND, either live or frozen at a lap.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- TICK_HZ, 10, tick rate; TICK_DIV = CLK_HZ/TICK_HZ (integer division, must be ≥2).
- DEB_MS, 20, debounce window; DEB_CYC = (CLK_HZ/1000)*DEB_MS (must be ≥1).
- i_clk  in  1  system clock, all logic on rising edge.
- i_reset  in  1  reset i_reset, asynchronous, active-low.
- i_btn_run  in  1  raw run/stop button, active-high, asynchronous to i_clk.
- i_btn_lap  in  1  raw lap/clear button, active-high, asynchronous.
- i_cnt_value  in  14  current counter value (min*1000+sec*10+tenths, 0..9599).
- o_tick  out  1  one-cycle count-enable pulse to counter.
- o_runstop  out  1  counter run enable.
- o_clear_n  out  1  active-low counter clear.
- o_disp_value  out  14  value to display.
- o_state  out  2  FSM state (IDLE=0, RUN=1, LAP=2, STOP=3).

## Operation
- Each button: 2-FF synchronizer, then debouncer. The debounced level changes only after the synchronized input has been stable and different for DEB_CYC consecutive cycles. A 0→1 debounced transition gives a one-cycle press pulse. Release produces no pulse.
- FSM on press pulses (run = run pulse, lap = lap pulse):
  - IDLE: run→RUN; lap ignored.
  - RUN: run→STOP; lap→LAP, latching i_cnt_value into the lap register that same cycle.
  - LAP: run→STOP; lap→RUN (display returns to live).
  - STOP: run→RUN; lap→IDLE and assert clear.
- Simultaneous run and lap pulses in one cycle: run wins; lap discarded.
- o_runstop = 1 in RUN and LAP, 0 in IDLE and STOP.
- Tick divider: counts 0..TICK_DIV-1 in RUN/LAP and wraps to 0. o_tick = 1 for the single cycle where the divider = TICK_DIV-1.
  - In STOP the divider holds its value, so a resumed run keeps the fractional period.
  - In IDLE the divider is held at 0.
- o_clear_n is driven low for exactly one cycle on the STOP→IDLE transition; otherwise high.
- o_disp_value is registered: in LAP it holds the lap register; in all other states it equals i_cnt_value delayed by one cycle.

## Timing
- Reset values (while i_reset=0):
  - state IDLE; o_state=0; o_runstop=0; o_tick=0.
  - o_clear_n=0 (holds counter cleared during reset).
  - o_disp_value=0; divider=0; lap register=0; debounced levels=0.
- Button latency: raw edge → press pulse after 2 sync cycles + DEB_CYC cycles. The state and o_runstop/o_state update on the cycle after the pulse.
- First o_tick after IDLE→RUN occurs TICK_DIV cycles after o_runstop rises.
- o_clear_n is low in the same cycle that o_state first reads IDLE.
- Reset asserted mid-operation: all of the above reset values apply immediately, and any in-progress debounce count is discarded.

## Configuration
- STOPWATCH_LAP_EN defined: LAP state, lap register and frozen display exist as above.
- Not defined:
  - No LAP state and no lap register.
  - The lap press is honoured only in STOP (→IDLE with clear) and ignored in RUN.
  - o_disp_value is always the one-cycle-delayed i_cnt_value.
  - o_state never reads 2.

## Structure
- Package stopwatch_pkg: state encodings, CNT_W=14, and the DEB_CYC/TICK_DIV derivation functions (shared with the counter and FND driver).
- Sub-module btn_debounce (synchronizer + stability counter + rising-edge pulse), instantiated twice; parameter DEB_CYC.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=10, DEB_MS=2, giving TICK_DIV=100 and DEB_CYC=2.
- Reset then 1-cycle glitch on i_btn_run → no press pulse; o_state stays 0, o_clear_n=1.
- Hold i_btn_run 10 cycles → o_state=1 and o_runstop=1 at cycle 2+2+1 after the edge; o_tick pulses every 100 cycles, first at 100 cycles after o_runstop rises.
- RUN for 250 cycles, run press, wait 500, run press → ticks resume 50 cycles after o_runstop returns high (divider held in STOP).
- RUN with i_cnt_value=1234, lap press → o_state=2 and o_disp_value frozen at 1234 while i_cnt_value advances; lap press again → o_disp_value follows input with 1-cycle lag.
- STOP, then lap press → o_clear_n low exactly 1 cycle, o_state=0. Pressing both buttons in the same cycle from STOP → o_state=1 and no clear.
- Assert i_reset during LAP → all outputs at reset values within the same cycle; after release, lap press alone leaves o_state=0.
